// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the button play detector: FSM state encoding,
// button-to-code mapping and small combinational helpers.
package detector_jogada_pkg;

  typedef enum logic [1:0] {
    ESPERA         = 2'd0,
    FILTRANDO      = 2'd1,
    PULSO          = 2'd2,
    AGUARDA_SOLTAR = 2'd3
  } estado_t;

  localparam logic [1:0] COD_BOTAO0 = 2'b00;
  localparam logic [1:0] COD_BOTAO1 = 2'b01;
  localparam logic [1:0] COD_BOTAO2 = 2'b10;
  localparam logic [1:0] COD_BOTAO3 = 2'b11;

  function automatic logic eh_one_hot(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  // Only called with a one-hot value; the default keeps the encoder total.
  function automatic logic [1:0] codifica(input logic [3:0] b);
    logic [1:0] c;
    case (b)
      4'b0001: c = COD_BOTAO0;
      4'b0010: c = COD_BOTAO1;
      4'b0100: c = COD_BOTAO2;
      4'b1000: c = COD_BOTAO3;
      default: c = COD_BOTAO0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to zero
// by an asynchronous active-low clear.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] est1_q;
  logic [WIDTH-1:0] est2_q;

  // Synchroniser chain register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      est1_q <= '0;
      est2_q <= '0;
    end else begin
      est1_q <= d_i;
      est2_q <= est1_q;
    end
  end

  assign q_o = est2_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces four push-buttons, emits a one-cycle play strobe with the
// encoded button, rejects multi-button presses and blocks auto-repeat.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int unsigned N_DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [1:0] codigo,
  output logic       jogada,
  output logic       invalida,
  output logic       ocupado
);

  localparam int unsigned CW = $clog2(N_DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(N_DEBOUNCE);

  logic [3:0]    sinc;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    amostra_q, amostra_d;
  logic [1:0]    codigo_q, codigo_d;
  logic          invalida_q, invalida_d;

  sincronizador_2ff #(.WIDTH(4)) u_sinc (
    .clock   (clock),
    .clear_n (clear_n),
    .d_i     (botoes),
    .q_o     (sinc)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state logic for the FSM, sample counter, holding register and outputs.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    amostra_d  = amostra_q;
    codigo_d   = codigo_q;
    invalida_d = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (habilita && eh_one_hot(sinc)) begin
          estado_d  = FILTRANDO;
          amostra_d = sinc;
          cnt_d     = CW'(1);
        end else if (habilita && (sinc != 4'd0)) begin
          estado_d   = AGUARDA_SOLTAR;
          invalida_d = 1'b1;
          cnt_d      = '0;
        end else begin
          estado_d = ESPERA;
        end
      end
      FILTRANDO: begin
        if (!habilita || (sinc != amostra_q)) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else if (cnt_inc == CNT_FIM) begin
          estado_d = PULSO;
          cnt_d    = cnt_inc;
          codigo_d = codifica(amostra_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PULSO: begin
        estado_d = AGUARDA_SOLTAR;
        cnt_d    = '0;
      end
      AGUARDA_SOLTAR: begin
        // Any bit seen restarts the release run: re-arming needs N clean samples.
        if (sinc != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_FIM) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        estado_d = ESPERA;
        cnt_d    = '0;
      end
    endcase
  end

  // State, counter, holding and output registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      estado_q   <= ESPERA;
      cnt_q      <= '0;
      amostra_q  <= 4'd0;
      codigo_q   <= 2'b00;
      invalida_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      amostra_q  <= amostra_d;
      codigo_q   <= codigo_d;
      invalida_q <= invalida_d;
    end
  end

  assign codigo   = codigo_q;
  assign invalida = invalida_q;
  assign jogada   = (estado_q == PULSO);
  assign ocupado  = (estado_q != ESPERA);

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: event-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_detector_jogada;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [1:0] codigo;
  logic       jogada, invalida, ocupado;
  logic [1:0] reg_q;

  int n_chk = 0, n_fail = 0;
  int neg_idx = 0, jog_cnt = 0, inv_cnt = 0, last_jog_idx = 0;
  bit chk_en = 1'b0;

  detector_jogada #(.N_DEBOUNCE(N)) dut (
    .clock    (clk),
    .clear_n  (clear_n),
    .habilita (habilita),
    .botoes   (botoes),
    .codigo   (codigo),
    .jogada   (jogada),
    .invalida (invalida),
    .ocupado  (ocupado)
  );

  always #10 clk = ~clk;

  // Downstream register fed by the strobe and code.
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) reg_q <= 2'b00;
    else if (jogada) reg_q <= codigo;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: presses are runs of identical one-hot samples; after a
  // play or a rejection the detector is disarmed until N zero samples.
  logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0, run_val = 4'd0;
  int   run_len = 0, zeros = 0;
  bit   armed = 1'b1, pulse = 1'b0, inval = 1'b0;
  logic [1:0] m_cod = 2'b00;

  function automatic logic [1:0] enc(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'b00;
  endfunction

  always @(posedge clk or negedge clear_n) begin
    logic [3:0] s;
    if (!clear_n) begin
      m_s1 = 4'd0; m_s2 = 4'd0; armed = 1'b1; run_len = 0; run_val = 4'd0;
      zeros = 0; pulse = 1'b0; inval = 1'b0; m_cod = 2'b00;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = botoes;
      inval = 1'b0;
      if (pulse) begin
        pulse = 1'b0;
        zeros = 0;
      end else if (!armed) begin
        if (s == 4'd0) begin
          zeros++;
          if (zeros == N) begin armed = 1'b1; zeros = 0; end
        end else zeros = 0;
      end else if (run_len > 0) begin
        if (!habilita || s != run_val) run_len = 0;
        else begin
          run_len++;
          if (run_len == N) begin
            m_cod = enc(run_val); pulse = 1'b1; armed = 1'b0; run_len = 0;
          end
        end
      end else if (habilita && s != 4'd0) begin
        if ($countones(s) == 1) begin run_val = s; run_len = 1; end
        else begin inval = 1'b1; armed = 1'b0; zeros = 0; end
      end
    end
  end

  // Per-cycle comparison and strobe bookkeeping, away from the active edge.
  always @(negedge clk) begin
    neg_idx++;
    if (jogada === 1'b1) begin jog_cnt++; last_jog_idx = neg_idx; end
    if (invalida === 1'b1) inv_cnt++;
    if (chk_en) begin
      chk("model_codigo", 32'(codigo), 32'(m_cod));
      chk("model_jogada", 32'(jogada), 32'(pulse));
      chk("model_invalida", 32'(invalida), 32'(inval));
      chk("model_ocupado", 32'(ocupado), 32'(!armed || run_len > 0 || pulse));
    end
  end

  task automatic drive(input logic [3:0] b, input logic h);
    @(negedge clk);
    #1;
    botoes = b;
    habilita = h;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, j0, i0;
    idle(3);
    chk("rst_codigo", 32'(codigo), 32'd0);
    chk("rst_jogada", 32'(jogada), 32'd0);
    chk("rst_invalida", 32'(invalida), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk); #1; clear_n = 1'b1; habilita = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Single clean press of button 2.
    j0 = jog_cnt;
    drive(4'b0100, 1'b1); t0 = neg_idx;
    idle(10);
    chk("t1_jog_count", 32'(jog_cnt - j0), 32'd1);
    chk("t1_latency", 32'(last_jog_idx - t0), 32'd6);
    chk("t1_codigo", 32'(codigo), 32'b10);
    chk("t1_reg_q", 32'(reg_q), 32'b10);
    drive(4'b0000, 1'b1); idle(8);

    // Bouncing button 0: on 2, off 1, then stable.
    j0 = jog_cnt;
    drive(4'b0001, 1'b1); drive(4'b0001, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1); t0 = neg_idx;
    idle(4);
    chk("t2_no_early_jog", 32'(jog_cnt - j0), 32'd0);
    idle(6);
    chk("t2_jog_count", 32'(jog_cnt - j0), 32'd1);
    chk("t2_latency", 32'(last_jog_idx - t0), 32'd6);
    chk("t2_codigo", 32'(codigo), 32'b00);
    drive(4'b0000, 1'b1); idle(8);

    // Two buttons together are rejected, then button 3 is accepted.
    j0 = jog_cnt; i0 = inv_cnt;
    drive(4'b1010, 1'b1); idle(6);
    chk("t3_inv_count", 32'(inv_cnt - i0), 32'd1);
    chk("t3_no_jog", 32'(jog_cnt - j0), 32'd0);
    chk("t3_codigo_kept", 32'(codigo), 32'b00);
    drive(4'b0000, 1'b1); idle(8);
    drive(4'b1000, 1'b1); idle(8);
    chk("t3_jog_count", 32'(jog_cnt - j0), 32'd1);
    chk("t3_codigo", 32'(codigo), 32'b11);
    drive(4'b0000, 1'b1); idle(8);

    // Press while disabled is ignored until habilita rises.
    j0 = jog_cnt;
    drive(4'b0010, 1'b0); idle(8);
    chk("t4_no_jog", 32'(jog_cnt - j0), 32'd0);
    chk("t4_ocupado", 32'(ocupado), 32'd0);
    drive(4'b0010, 1'b1); idle(8);
    chk("t4_jog_count", 32'(jog_cnt - j0), 32'd1);
    chk("t4_codigo", 32'(codigo), 32'b01);
    drive(4'b0000, 1'b1); idle(8);

    // habilita dropping mid-filter aborts the press.
    j0 = jog_cnt;
    drive(4'b0001, 1'b1); idle(3);
    drive(4'b0001, 1'b0); idle(8);
    chk("t5_abort", 32'(jog_cnt - j0), 32'd0);
    chk("t5_codigo", 32'(codigo), 32'b01);
    drive(4'b0000, 1'b1); idle(8);

    // Asynchronous reset mid-filter, button held through release.
    j0 = jog_cnt;
    drive(4'b0100, 1'b1); idle(3);
    #5 clear_n = 1'b0;
    #1;
    chk("t6_async_codigo", 32'(codigo), 32'd0);
    chk("t6_async_jogada", 32'(jogada), 32'd0);
    chk("t6_async_invalida", 32'(invalida), 32'd0);
    chk("t6_async_ocupado", 32'(ocupado), 32'd0);
    idle(2);
    @(negedge clk); #1; clear_n = 1'b1; t0 = neg_idx;
    idle(10);
    chk("t6_jog_count", 32'(jog_cnt - j0), 32'd1);
    chk("t6_latency", 32'(last_jog_idx - t0), 32'd6);
    chk("t6_codigo", 32'(codigo), 32'b10);
    drive(4'b0000, 1'b1); idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
